// File: rtl/serial_detector_arbiter.sv
// Round-robin owner of a shared serial pattern detector: grant, clear, stream
// FRAME_LEN bits from the owner, then report whether the detector fired.
module serial_detector_arbiter #(
  parameter  int NREQ      = 4,
  parameter  int FRAME_LEN = 8,
  localparam int OW        = $clog2(NREQ),
  localparam int CW        = $clog2(FRAME_LEN + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] bit_in,
  output logic [NREQ-1:0] grant,
  output logic [OW-1:0]   owner,
  output logic            det_clear,
  output logic            det_in,
  input  logic            det_out,
  output logic            done,
  output logic            hit
);

  typedef enum logic [1:0] {IDLE, CLEAR, STREAM, REPORT} state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   last_q,  last_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic            acc_q,   acc_d;
  logic            clr_q,   clr_d;
  logic            done_q,  done_d;
  logic            hit_q,   hit_d;
  logic [OW-1:0]   sel;
  logic            found;

  // NREQ need not be a power of two, so the index wraps explicitly.
  function automatic logic [OW-1:0] wrap_add(input logic [OW-1:0] base, input int step);
    int s;
    s = int'(base) + step;
    if (s >= NREQ) s = s - NREQ;
    return OW'(s);
  endfunction

  always_comb begin
    found = 1'b0;
    sel   = last_q;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && req[wrap_add(last_q, i)]) begin
        found = 1'b1;
        sel   = wrap_add(last_q, i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    clr_d   = 1'b0;
    done_d  = 1'b0;
    hit_d   = hit_q;
    case (state_q)
      IDLE: if (found) begin
        owner_d      = sel;
        last_d       = sel;
        grant_d      = '0;
        grant_d[sel] = 1'b1;
        clr_d        = 1'b1;
        state_d      = CLEAR;
      end
      CLEAR: begin
        acc_d   = 1'b0;
        cnt_d   = '0;
        state_d = STREAM;
      end
      STREAM: begin
        // det_out lags det_in by one cycle, so the first STREAM cycle carries nothing.
        if (cnt_q != '0) acc_d = acc_q | det_out;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = REPORT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      REPORT: begin
        hit_d   = acc_q | det_out;
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= OW'(NREQ - 1);
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
      hit_q   <= hit_d;
    end
  end

  assign grant     = grant_q;
  assign owner     = owner_q;
  assign det_clear = clr_q;
  assign done      = done_q;
  assign det_in    = (state_q == STREAM) ? bit_in[owner_q] : 1'b0;
  // The response to the final bit only appears during REPORT, so fold it in live.
  assign hit       = (state_q == REPORT) ? (acc_q | det_out) : hit_q;

endmodule
